// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 shared constants, round-constant lookup and FSM state encodings
// for the key expander and the state manager.
package aes_pkg;
    localparam int AES_NR    = 10;
    localparam int AES_NK    = 4;
    localparam int AES_WORDS = AES_NK * (AES_NR + 1);

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_LOAD   = 2'd1,
        KS_EXPAND = 2'd2,
        KS_DONE   = 2'd3
    } ks_state_t;

    typedef enum logic [2:0] {
        SM_IDLE              = 3'd0,
        SM_PTEXT_WRITE       = 3'd1,
        SM_KEY_WRITE         = 3'd2,
        SM_COMPUTE_ROUNDKEYS = 3'd3,
        SM_ROUNDS            = 3'd4,
        SM_OUTPUT            = 3'd5
    } sm_state_t;

    function automatic logic [7:0] aes_rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, shared by SubWord and SubBytes.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] substituted
);
    // Entry 0 sits in the top byte, so entry v starts at bit 8*(255-v) = {~v, 3'b000}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign substituted = SBOX[{~value, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128 key schedule; loads four key words, expands one word per
// cycle into 44 stored words and serves them through a combinational read port.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              key_start,
    input  logic [WORD_W-1:0] key_word_in,
    input  logic [3:0]        rk_round,
    input  logic [1:0]        rk_col,
    output logic [WORD_W-1:0] rk_word,
    output logic              key_expand_done,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    localparam int NW = AES_NK * (NR + 1);

    ks_state_t         state, state_next;
    logic [5:0]        i;
    logic [3:0]        rcon_idx;
    logic [WORD_W-1:0] w [NW];
    logic [WORD_W-1:0] prev, rot, sub, w_new;
    logic              last_word, wr_en;
    logic [5:0]        rd_idx;

    assign last_word = i == 6'(NW - 1);
    assign wr_en     = !key_start && (state == KS_LOAD || state == KS_EXPAND);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= KS_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        if (key_start) state_next = KS_LOAD;
        else if (state == KS_LOAD && i == 6'd3) state_next = KS_EXPAND;
        else if (state == KS_EXPAND && last_word) state_next = KS_DONE;
    end

    // The counter parks at the final word so DONE never indexes past the array.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            i        <= '0;
            rcon_idx <= 4'd1;
        end else if (key_start) begin
            i        <= '0;
            rcon_idx <= 4'd1;
        end else if (state == KS_LOAD || (state == KS_EXPAND && !last_word)) begin
            i <= i + 6'd1;
            if (state == KS_EXPAND && i[1:0] == 2'b00 && rcon_idx != 4'(NR))
                rcon_idx <= rcon_idx + 4'd1;
        end

    assign prev = w[i - 6'd1];
    assign rot  = {prev[WORD_W-9:0], prev[WORD_W-1 -: 8]};

    for (genvar b = 0; b < WORD_W / 8; b++) begin : g_sbox
        aes_sbox u_sbox (
            .value       (rot[8*b +: 8]),
            .substituted (sub[8*b +: 8])
        );
    end

    assign w_new = w[i - 6'd4] ^ (i[1:0] == 2'b00 ?
                   sub ^ {aes_rcon(rcon_idx), {(WORD_W - 8){1'b0}}} : prev);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            for (int k = 0; k < NW; k++) w[k] <= '0;
        end else if (wr_en) begin
            w[i] <= state == KS_LOAD ? key_word_in : w_new;
        end

    assign rd_idx          = {rk_round, rk_col};
    assign rk_word         = rk_round <= 4'(NR) ? w[rd_idx] : '0;
    assign key_expand_done = state == KS_DONE;
    assign busy            = state == KS_LOAD || state == KS_EXPAND;
    assign dbg_state       = state;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed vector bench for the AES-128 key expander.
module tb_aes_key_expander;
    logic        clock = 0;
    logic        reset_n;
    logic        key_start;
    logic [31:0] key_word_in;
    logic [3:0]  rk_round;
    logic [1:0]  rk_col;
    logic [31:0] rk_word;
    logic        key_expand_done;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int passed = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ONES_KEY = {128{1'b1}};

    typedef struct {
        logic [3:0]  r;
        logic [1:0]  c;
        logic [31:0] fips;
        logic [31:0] zero;
    } vec_t;
    vec_t tbl [14];

    aes_key_expander dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .key_start       (key_start),
        .key_word_in     (key_word_in),
        .rk_round        (rk_round),
        .rk_col          (rk_col),
        .rk_word         (rk_word),
        .key_expand_done (key_expand_done),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic read_word(input int r, input int c, output logic [31:0] v);
        rk_round = 4'(r);
        rk_col   = 2'(c);
        #1 v = rk_word;
    endtask

    // lat = cycles from the key_start sampling edge until done is seen; -1 if never.
    task automatic drive_key(input logic [127:0] key, input int max_c, output int lat);
        lat = -1;
        @(negedge clock);
        key_start   = 1;
        key_word_in = 32'hdeadbeef;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clock);
            key_start = 0;
            if (c == 1) begin
                chk("load_state", {30'b0, dbg_state}, 32'd1);
                chk("load_busy", {31'b0, busy}, 32'd1);
                chk("load_done", {31'b0, key_expand_done}, 32'd0);
            end
            if (key_expand_done) begin
                lat = c - 1;
                break;
            end
            key_word_in = c <= 4 ? key[32*(4-c) +: 32] : 32'h0;
        end
    endtask

    task automatic check_table(input bit use_zero, input string tag);
        logic [31:0] v;
        for (int n = 0; n < 14; n++) begin
            read_word(int'(tbl[n].r), int'(tbl[n].c), v);
            chk($sformatf("%s_r%0d_c%0d", tag, tbl[n].r, tbl[n].c), v,
                use_zero ? tbl[n].zero : tbl[n].fips);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] v;
        tbl[0]  = '{4'd0,  2'd0, 32'h2b7e1516, 32'h00000000};
        tbl[1]  = '{4'd0,  2'd3, 32'h09cf4f3c, 32'h00000000};
        tbl[2]  = '{4'd1,  2'd0, 32'ha0fafe17, 32'h62636363};
        tbl[3]  = '{4'd1,  2'd1, 32'h88542cb1, 32'h62636363};
        tbl[4]  = '{4'd1,  2'd2, 32'h23a33939, 32'h62636363};
        tbl[5]  = '{4'd1,  2'd3, 32'h2a6c7605, 32'h62636363};
        tbl[6]  = '{4'd2,  2'd0, 32'hf2c295f2, 32'h9b9898c9};
        tbl[7]  = '{4'd2,  2'd1, 32'h7a96b943, 32'hf9fbfbaa};
        tbl[8]  = '{4'd5,  2'd0, 32'hd4d1c6f8, 32'h7f2e2b88};
        tbl[9]  = '{4'd9,  2'd3, 32'h575c006e, 32'h4c664941};
        tbl[10] = '{4'd10, 2'd0, 32'hd014f9a8, 32'hb4ef5bcb};
        tbl[11] = '{4'd10, 2'd1, 32'hc9ee2589, 32'h3e92e211};
        tbl[12] = '{4'd10, 2'd2, 32'he13f0cc8, 32'h23e951cf};
        tbl[13] = '{4'd10, 2'd3, 32'hb6630ca6, 32'h6f8f188e};

        reset_n = 0; key_start = 0; key_word_in = 0; rk_round = 0; rk_col = 0;
        repeat (2) @(negedge clock);
        chk("rst_done", {31'b0, key_expand_done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        read_word(0, 0, v);  chk("rst_w0", v, 32'h0);
        read_word(10, 3, v); chk("rst_w43", v, 32'h0);
        reset_n = 1;

        drive_key(FIPS_KEY, 60, lat);
        chk("fips_latency", 32'(lat), 32'd44);
        chk("fips_busy", {31'b0, busy}, 32'd0);
        chk("fips_state", {30'b0, dbg_state}, 32'd3);
        check_table(0, "fips");
        for (int r = 11; r <= 15; r++)
            for (int c = 0; c < 4; c++) begin
                read_word(r, c, v);
                chk($sformatf("oob_r%0d_c%0d", r, c), v, 32'h0);
            end

        drive_key(ZERO_KEY, 60, lat);
        chk("zero_latency", 32'(lat), 32'd44);
        check_table(1, "zero");

        drive_key(ONES_KEY, 24, lat);
        chk("abort_state", {30'b0, dbg_state}, 32'd2);
        chk("abort_done", {31'b0, key_expand_done}, 32'd0);
        drive_key(FIPS_KEY, 60, lat);
        chk("restart_latency", 32'(lat), 32'd44);
        check_table(0, "restart");

        drive_key(FIPS_KEY, 30, lat);
        chk("mid_state", {30'b0, dbg_state}, 32'd2);
        reset_n = 0;
        #1;
        chk("mrst_done", {31'b0, key_expand_done}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_state", {30'b0, dbg_state}, 32'd0);
        for (int r = 0; r <= 10; r++)
            for (int c = 0; c < 4; c++) begin
                read_word(r, c, v);
                chk($sformatf("mrst_r%0d_c%0d", r, c), v, 32'h0);
            end
        @(negedge clock);
        reset_n = 1;
        drive_key(ZERO_KEY, 60, lat);
        chk("post_rst_latency", 32'(lat), 32'd44);
        check_table(1, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
